// File: rtl/memory_nrw_wb.sv
// rtl/memory_nrw_wb.sv - N-port pipelined Wishbone testbench memory
// Shared byte array with misaligned 32-bit access, fixed response latency and optional LFSR stalls.
module memory_nrw_wb #(
  parameter int          NUM_PORTS  = 2,
  parameter int          ADDR_WIDTH = 9,
  parameter int          LATENCY    = 1,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_PORTS-1:0]      wb_cyc_i,
  input  logic [NUM_PORTS-1:0]      wb_stb_i,
  input  logic [NUM_PORTS-1:0]      wb_we_i,
  input  logic [32*NUM_PORTS-1:0]   wb_adr_i,
  input  logic [32*NUM_PORTS-1:0]   wb_dat_i,
  input  logic [4*NUM_PORTS-1:0]    wb_sel_i,
  output logic [NUM_PORTS-1:0]      wb_stall_o,
  output logic [NUM_PORTS-1:0]      wb_ack_o,
  output logic [NUM_PORTS-1:0]      wb_err_o,
  output logic [32*NUM_PORTS-1:0]   wb_dat_o
);

  localparam int            BW      = ADDR_WIDTH + 2;
  localparam int            DEPTH   = 1 << BW;
  localparam logic [BW-1:0] LAST_OK = BW'(DEPTH - 4);

  logic [7:0]           mem     [DEPTH];
  logic [15:0]          lfsr    [NUM_PORTS];
  logic [BW-1:0]        badr    [NUM_PORTS];
  logic [31:0]          rd_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] accept;
  logic [NUM_PORTS-1:0] in_range;
  logic [LATENCY-1:0]   pipe_v  [NUM_PORTS];
  logic [LATENCY-1:0]   pipe_e  [NUM_PORTS];
  logic [31:0]          pipe_d  [NUM_PORTS][LATENCY];

  function automatic logic [15:0] port_seed(input int p);
    logic [15:0] s;
    s = STALL_SEED ^ 16'(p);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  always_ff @(posedge wb_clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wb_rst_i) lfsr[p] <= port_seed(p);
      else          lfsr[p] <= {lfsr[p][0] ^ lfsr[p][2] ^ lfsr[p][3] ^ lfsr[p][5], lfsr[p][15:1]};
    end
  end

  always_comb begin
    wb_stall_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wb_stall_o[p] = STALL_EN && (lfsr[p][1:0] == 2'b00);
    end
  end

  // Read data is taken from the array before this edge's writes land, giving read-old semantics.
  always_comb begin
    accept   = '0;
    in_range = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      badr[p]     = wb_adr_i[32*p +: BW];
      in_range[p] = ((wb_adr_i[32*p +: 32] >> BW) == 32'd0) && (badr[p] <= LAST_OK);
      accept[p]   = wb_cyc_i[p] && wb_stb_i[p] && !wb_stall_o[p] && !wb_rst_i;
      rd_data[p]  = {mem[badr[p] + BW'(3)], mem[badr[p] + BW'(2)],
                     mem[badr[p] + BW'(1)], mem[badr[p]]};
    end
  end

  // Highest port is applied first so the lowest port index wins a byte collision.
  always_ff @(posedge wb_clk_i) begin
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (accept[p] && wb_we_i[p] && in_range[p]) begin
        for (int i = 0; i < 4; i++) begin
          if (wb_sel_i[4*p + i]) mem[badr[p] + BW'(i)] <= wb_dat_i[32*p + 8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wb_rst_i || !wb_cyc_i[p]) begin
        pipe_v[p] <= '0;
        pipe_e[p] <= '0;
        for (int s = 0; s < LATENCY; s++) pipe_d[p][s] <= 32'd0;
      end else begin
        pipe_v[p][0] <= accept[p];
        pipe_e[p][0] <= accept[p] && !in_range[p];
        pipe_d[p][0] <= (accept[p] && !wb_we_i[p] && in_range[p]) ? rd_data[p] : 32'd0;
        for (int s = 1; s < LATENCY; s++) begin
          pipe_v[p][s] <= pipe_v[p][s-1];
          pipe_e[p][s] <= pipe_e[p][s-1];
          pipe_d[p][s] <= pipe_d[p][s-1];
        end
      end
    end
  end

  // Gating with cyc drops a response in the very cycle the master abandons the cycle.
  always_comb begin
    logic last_v;
    wb_ack_o = '0;
    wb_err_o = '0;
    wb_dat_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      last_v               = pipe_v[p][LATENCY-1] && wb_cyc_i[p];
      wb_ack_o[p]          = last_v && !pipe_e[p][LATENCY-1];
      wb_err_o[p]          = last_v && pipe_e[p][LATENCY-1];
      wb_dat_o[32*p +: 32] = last_v ? pipe_d[p][LATENCY-1] : 32'd0;
    end
  end

endmodule

// File: tb/tb_memory_nrw_wb.sv
// tb/tb_memory_nrw_wb.sv - directed and stall-stress bench for memory_nrw_wb
module tb_memory_nrw_wb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Instance A: 3 ports, latency 1, no stalls
  logic [2:0]  a_cyc, a_stb, a_we, a_stall, a_ack, a_err;
  logic [95:0] a_adr, a_dat_w, a_dat_r;
  logic [11:0] a_sel;

  // Instance B: 1 port, latency 3, no stalls
  logic [0:0]  b_cyc, b_stb, b_we, b_stall, b_ack, b_err;
  logic [31:0] b_adr, b_dat_w, b_dat_r;
  logic [3:0]  b_sel;

  // Instance C: 2 ports, latency 2, stall injection
  logic [1:0]  c_cyc, c_stb, c_we, c_stall, c_ack, c_err;
  logic [63:0] c_adr, c_dat_w, c_dat_r;
  logic [7:0]  c_sel;

  logic [7:0]  ref_c [64];
  logic [31:0] b_words [4];

  memory_nrw_wb #(.NUM_PORTS(3), .ADDR_WIDTH(9), .LATENCY(1), .STALL_EN(1'b0)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_we_i(a_we),
    .wb_adr_i(a_adr), .wb_dat_i(a_dat_w), .wb_sel_i(a_sel), .wb_stall_o(a_stall),
    .wb_ack_o(a_ack), .wb_err_o(a_err), .wb_dat_o(a_dat_r));

  memory_nrw_wb #(.NUM_PORTS(1), .ADDR_WIDTH(4), .LATENCY(3), .STALL_EN(1'b0)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_we_i(b_we),
    .wb_adr_i(b_adr), .wb_dat_i(b_dat_w), .wb_sel_i(b_sel), .wb_stall_o(b_stall),
    .wb_ack_o(b_ack), .wb_err_o(b_err), .wb_dat_o(b_dat_r));

  memory_nrw_wb #(.NUM_PORTS(2), .ADDR_WIDTH(4), .LATENCY(2), .STALL_EN(1'b1),
                  .STALL_SEED(16'hACE1)) dut_c (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(c_cyc), .wb_stb_i(c_stb), .wb_we_i(c_we),
    .wb_adr_i(c_adr), .wb_dat_i(c_dat_w), .wb_sel_i(c_sel), .wb_stall_o(c_stall),
    .wb_ack_o(c_ack), .wb_err_o(c_err), .wb_dat_o(c_dat_r));

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {ref_c[a+3], ref_c[a+2], ref_c[a+1], ref_c[a]};
  endfunction

  task automatic a_req(input int p, input bit we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    a_stb[p] = 1'b1;
    a_we[p]  = we;
    a_adr[32*p +: 32]   = adr;
    a_dat_w[32*p +: 32] = dat;
    a_sel[4*p +: 4]     = sel;
  endtask

  task automatic a_idle();
    a_stb = '0;
    a_we  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_cyc = '0; a_stb = '0; a_we = '0; a_adr = '0; a_dat_w = '0; a_sel = '0;
    b_cyc = '0; b_stb = '0; b_we = '0; b_adr = '0; b_dat_w = '0; b_sel = '0;
    c_cyc = '0; c_stb = '0; c_we = '0; c_adr = '0; c_dat_w = '0; c_sel = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (a_ack !== 3'b000) $display("FAIL reset_a_ack: got %b want 000", a_ack); else pass_cnt++;
    total_cnt++; if (a_err !== 3'b000) $display("FAIL reset_a_err: got %b want 000", a_err); else pass_cnt++;
    total_cnt++; if (a_dat_r !== 96'd0) $display("FAIL reset_a_dat: got %h want 0", a_dat_r); else pass_cnt++;
    total_cnt++; if (a_stall !== 3'b000) $display("FAIL reset_a_stall: got %b want 000", a_stall); else pass_cnt++;
    total_cnt++; if (b_ack !== 1'b0 || b_stall !== 1'b0) $display("FAIL reset_b: got ack %b stall %b want 0 0", b_ack, b_stall); else pass_cnt++;
    total_cnt++; if (c_ack !== 2'b00) $display("FAIL reset_c_ack: got %b want 00", c_ack); else pass_cnt++;
    total_cnt++; if (c_stall !== 2'b10) $display("FAIL reset_c_stall_seed: got %b want 10", c_stall); else pass_cnt++;
    rst = 1'b0;
    a_cyc = '1; b_cyc = '1; c_cyc = '1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    a_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    total_cnt++; if (a_ack[0] !== 1'b1 || a_dat_r[31:0] !== 32'd0) $display("FAIL basic_write_ack: got ack %b dat %h want 1 0", a_ack[0], a_dat_r[31:0]); else pass_cnt++;
    a_idle();
    a_req(1, 1'b0, 32'h100, 32'd0, 4'h0);
    @(negedge clk);
    total_cnt++; if (a_ack[1] !== 1'b1) $display("FAIL basic_read_ack: got %b want 1", a_ack[1]); else pass_cnt++;
    total_cnt++; if (a_dat_r[63:32] !== 32'hDEADBEEF) $display("FAIL basic_read_dat: got %h want deadbeef", a_dat_r[63:32]); else pass_cnt++;
    a_idle();
    @(negedge clk);
    total_cnt++; if (a_ack !== 3'b000 || a_dat_r !== 96'd0) $display("FAIL basic_idle: got ack %b dat %h want 000 0", a_ack, a_dat_r); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    a_req(0, 1'b1, 32'h100, 32'd0, 4'hF);
    a_req(1, 1'b1, 32'h104, 32'd0, 4'hF);
    @(negedge clk);
    a_idle();
    a_req(0, 1'b1, 32'h101, 32'h11223344, 4'hF);
    @(negedge clk);
    a_idle();
    a_req(0, 1'b0, 32'h100, 32'd0, 4'h0);
    a_req(1, 1'b0, 32'h104, 32'd0, 4'h3);
    @(negedge clk);
    total_cnt++; if (a_dat_r[31:0] !== 32'h22334400) $display("FAIL misaligned_lo: got %h want 22334400", a_dat_r[31:0]); else pass_cnt++;
    total_cnt++; if (a_dat_r[63:32] !== 32'h00000011) $display("FAIL misaligned_hi: got %h want 00000011", a_dat_r[63:32]); else pass_cnt++;
    a_idle();
  endtask

  task automatic test_collision();
    a_req(0, 1'b1, 32'h20, 32'd0, 4'hF);
    @(negedge clk);
    a_idle();
    a_req(0, 1'b1, 32'h20, 32'h000000AA, 4'h1);
    a_req(1, 1'b1, 32'h20, 32'h0000CCBB, 4'h3);
    a_req(2, 1'b0, 32'h20, 32'd0, 4'h0);
    @(negedge clk);
    total_cnt++; if (a_ack[2] !== 1'b1 || a_dat_r[95:64] !== 32'd0) $display("FAIL collision_same_edge_read: got ack %b dat %h want 1 0", a_ack[2], a_dat_r[95:64]); else pass_cnt++;
    a_idle();
    a_req(2, 1'b0, 32'h20, 32'd0, 4'h0);
    @(negedge clk);
    total_cnt++; if (a_dat_r[95:64] !== 32'h0000CCAA) $display("FAIL collision_winner: got %h want 0000ccaa", a_dat_r[95:64]); else pass_cnt++;
    a_idle();
  endtask

  task automatic test_out_of_range();
    a_req(0, 1'b1, 32'h7FC, 32'h55667788, 4'hF);
    @(negedge clk);
    a_idle();
    a_req(0, 1'b0, 32'h800, 32'd0, 4'h0);
    a_req(1, 1'b1, 32'h7FE, 32'hFFFFFFFF, 4'hF);
    a_req(2, 1'b0, 32'h10000100, 32'd0, 4'h0);
    @(negedge clk);
    total_cnt++; if (a_err[0] !== 1'b1 || a_ack[0] !== 1'b0 || a_dat_r[31:0] !== 32'd0) $display("FAIL oor_read: got err %b ack %b dat %h want 1 0 0", a_err[0], a_ack[0], a_dat_r[31:0]); else pass_cnt++;
    total_cnt++; if (a_err[1] !== 1'b1 || a_ack[1] !== 1'b0) $display("FAIL oor_write: got err %b ack %b want 1 0", a_err[1], a_ack[1]); else pass_cnt++;
    total_cnt++; if (a_err[2] !== 1'b1 || a_ack[2] !== 1'b0) $display("FAIL oor_high_bits: got err %b ack %b want 1 0", a_err[2], a_ack[2]); else pass_cnt++;
    a_idle();
    a_req(2, 1'b0, 32'h7FC, 32'd0, 4'h0);
    @(negedge clk);
    total_cnt++; if (a_ack[2] !== 1'b1 || a_err[2] !== 1'b0 || a_dat_r[95:64] !== 32'h55667788) $display("FAIL oor_last_word: got ack %b err %b dat %h want 1 0 55667788", a_ack[2], a_err[2], a_dat_r[95:64]); else pass_cnt++;
    a_idle();
  endtask

  task automatic b_burst(input bit we, input bit drop, output int nacks, output int bad);
    nacks = 0;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (b_ack[0]) begin
        if (n != nacks + 3) bad++;
        if (b_dat_r !== (we ? 32'd0 : (nacks < 4 ? b_words[nacks] : 32'd0))) bad++;
        nacks++;
        if (drop && nacks == 2) b_cyc = 1'b0;
      end
      if (b_err[0]) bad++;
      if (n < 4) begin
        b_stb = 1'b1; b_we = we; b_adr = 32'(4 * n); b_dat_w = b_words[n]; b_sel = 4'hF;
      end else begin
        b_stb = 1'b0; b_we = 1'b0;
      end
      @(negedge clk);
    end
    b_cyc = 1'b1;
  endtask

  task automatic test_back_to_back();
    int nacks, bad;
    b_words[0] = 32'hA0A1A2A3; b_words[1] = 32'hB0B1B2B3;
    b_words[2] = 32'hC0C1C2C3; b_words[3] = 32'hD0D1D2D3;
    b_burst(1'b1, 1'b0, nacks, bad);
    total_cnt++; if (nacks != 4 || bad != 0) $display("FAIL b2b_writes: got acks %0d bad %0d want 4 0", nacks, bad); else pass_cnt++;
    b_burst(1'b0, 1'b0, nacks, bad);
    total_cnt++; if (nacks != 4) $display("FAIL b2b_read_acks: got %0d want 4", nacks); else pass_cnt++;
    total_cnt++; if (bad != 0) $display("FAIL b2b_read_timing_data: got %0d errors want 0", bad); else pass_cnt++;
  endtask

  task automatic test_cyc_drop();
    int nacks, bad;
    b_burst(1'b0, 1'b1, nacks, bad);
    total_cnt++; if (nacks != 2) $display("FAIL cyc_drop_acks: got %0d want 2", nacks); else pass_cnt++;
    total_cnt++; if (bad != 0) $display("FAIL cyc_drop_data: got %0d errors want 0", bad); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    b_stb = 1'b1; b_we = 1'b0; b_adr = 32'h4;
    @(negedge clk);
    b_stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (b_ack !== 1'b0) $display("FAIL reset_mid_ack: got %b want 0", b_ack); else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b_ack[0] || b_err[0]) acks++;
    end
    total_cnt++; if (acks != 0) $display("FAIL reset_mid_late_ack: got %0d responses want 0", acks); else pass_cnt++;
  endtask

  task automatic test_mem_kept();
    a_req(0, 1'b0, 32'h100, 32'd0, 4'h0);
    @(negedge clk);
    total_cnt++; if (a_dat_r[31:0] !== 32'h22334400) $display("FAIL mem_kept_after_reset: got %h want 22334400", a_dat_r[31:0]); else pass_cnt++;
    a_idle();
  endtask

  task automatic c_write(input logic [31:0] adr, input logic [31:0] dat, output bit ok);
    int guard = 0;
    c_stb[0] = 1'b1; c_we[0] = 1'b1; c_adr[31:0] = adr; c_dat_w[31:0] = dat; c_sel[3:0] = 4'hF;
    while (c_stall[0] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = (guard < 100);
    @(negedge clk);
    c_stb[0] = 1'b0; c_we[0] = 1'b0;
  endtask

  task automatic c_port_run(input int p, input int n, output int acc, output int acks, output int bad);
    logic [31:0] q[$];
    logic [31:0] exp_d;
    bit have = 1'b0;
    int adr = 0;
    int cyc_n = 0;
    acc = 0; acks = 0; bad = 0;
    while ((acc < n || q.size() > 0) && cyc_n < 20000) begin
      if (c_ack[p]) begin
        acks++;
        if (q.size() == 0) bad++;
        else begin
          exp_d = q.pop_front();
          if (c_dat_r[32*p +: 32] !== exp_d) bad++;
        end
      end
      if (c_err[p]) bad++;
      if (acc < n) begin
        if (!have) begin
          adr = int'($urandom_range(0, 60));
          have = 1'b1;
        end
        c_stb[p] = 1'b1; c_we[p] = 1'b0; c_adr[32*p +: 32] = 32'(adr);
        if (!c_stall[p]) begin
          q.push_back(ref_word(adr));
          acc++;
          have = 1'b0;
        end
      end else begin
        c_stb[p] = 1'b0;
      end
      @(negedge clk);
      cyc_n++;
    end
    c_stb[p] = 1'b0;
  endtask

  task automatic test_stall_random();
    int acc0, ack0, bad0, acc1, ack1, bad1;
    int init_bad = 0;
    bit ok;
    for (int i = 0; i < 64; i++) ref_c[i] = 8'(i * 37 + 5);
    for (int w = 0; w < 16; w++) begin
      c_write(32'(4 * w), ref_word(4 * w), ok);
      if (!ok) init_bad++;
    end
    total_cnt++; if (init_bad != 0) $display("FAIL stall_init_timeout: got %0d timeouts want 0", init_bad); else pass_cnt++;
    repeat (3) @(negedge clk);
    fork
      c_port_run(0, 1000, acc0, ack0, bad0);
      c_port_run(1, 1000, acc1, ack1, bad1);
    join
    total_cnt++; if (acc0 != 1000 || acc1 != 1000) $display("FAIL stall_accepts: got %0d %0d want 1000 1000", acc0, acc1); else pass_cnt++;
    total_cnt++; if (ack0 != acc0) $display("FAIL stall_acks_p0: got %0d want %0d", ack0, acc0); else pass_cnt++;
    total_cnt++; if (ack1 != acc1) $display("FAIL stall_acks_p1: got %0d want %0d", ack1, acc1); else pass_cnt++;
    total_cnt++; if (bad0 != 0 || bad1 != 0) $display("FAIL stall_data: got errors %0d %0d want 0 0", bad0, bad1); else pass_cnt++;
  endtask

  task automatic test_stall_reset();
    logic [15:0] l0 = 16'hACE1;
    logic [15:0] l1 = 16'hACE0;
    int mism = 0;
    int acks = 0;
    c_stb = 2'b11; c_we = 2'b00; c_adr = {32'd8, 32'd4};
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (c_ack !== 2'b00) $display("FAIL stall_reset_ack: got %b want 00", c_ack); else pass_cnt++;
    total_cnt++; if (c_stall !== 2'b10) $display("FAIL stall_reset_seed: got %b want 10", c_stall); else pass_cnt++;
    rst = 1'b0;
    c_stb = 2'b00;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      l0 = lfsr_next(l0);
      l1 = lfsr_next(l1);
      if (c_stall !== {l1[1:0] == 2'b00, l0[1:0] == 2'b00}) mism++;
      if (c_ack !== 2'b00) acks++;
    end
    total_cnt++; if (mism != 0) $display("FAIL stall_sequence: got %0d mismatching cycles want 0", mism); else pass_cnt++;
    total_cnt++; if (acks != 0) $display("FAIL stall_reset_late_ack: got %0d want 0", acks); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_cyc_drop();
    test_reset_mid();
    test_mem_kept();
    test_stall_random();
    test_stall_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
